surf_l0_scaler_block: RTL and testbench

- Downstream consumer of the 32-bit scaler pulse bus driven by the TURF trigger processor. That bus carries L0 per-channel hits, L1/L2 trigger scalers and the registered reference pulse.
- Counts rising edges per channel over a gate period, then atomically latches all counts into a shadow bank.
- The shadow bank is read out by the SURF register interface through an addressed, one-cycle-latency read port with a new-data/ack handshake.

---
 rtl/surf_scaler_pkg.sv | 15 +
 rtl/surf_scaler_counter.sv | 57 +++++
 rtl/surf_l0_scaler_block.sv | 126 ++++++++++++
 tb/tb_surf_l0_scaler_block.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/surf_scaler_pkg.sv
// Shared constants and gate-mode encoding for the SURF L0 scaler block.
package surf_scaler_pkg;

  localparam int NCHAN_DEF       = 32;
  localparam int COUNT_W_DEF     = 16;
  localparam int PERIOD_33MHZ_1S = 33_000_000;
  localparam int REF_BIT_DEF     = 21;

  // Gate source: free-running internal timer or rising edges of the reference bit.
  typedef enum logic {
    GATE_INTERNAL = 1'b0,
    GATE_REF      = 1'b1
  } gate_sel_e;

endpackage

// File: rtl/surf_scaler_counter.sv
// One scaler channel: rising-edge detect, saturating live counter and shadow latch.
module surf_scaler_counter
  import surf_scaler_pkg::*;
#(
  parameter int COUNT_W = COUNT_W_DEF
) (
  input  logic               mclk_i,
  input  logic               rst_n_i,
  input  logic               pulse_i,
  input  logic               boundary_i,
  output logic [COUNT_W-1:0] live_o,
  output logic [COUNT_W-1:0] shadow_o
);

  logic               prev_q, prev_d;
  logic [COUNT_W-1:0] live_q, live_d;
  logic [COUNT_W-1:0] shadow_q, shadow_d;
  logic               hit;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
    if (&v) return v;
    return v + 1'b1;
  endfunction

  // Edge detect, count, and on a gate boundary hand the finished count to the shadow.
  always_comb begin
    hit      = pulse_i & ~prev_q;
    prev_d   = pulse_i;
    live_d   = live_q;
    shadow_d = shadow_q;
    if (boundary_i) begin
      // The shadow takes the count before this cycle's edge; that edge opens the new period.
      shadow_d = live_q;
      live_d   = hit ? {{(COUNT_W-1){1'b0}}, 1'b1} : '0;
    end else if (hit) begin
      live_d = sat_inc(live_q);
    end
  end

  // Channel state registers.
  always_ff @(posedge mclk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      prev_q   <= 1'b0;
      live_q   <= '0;
      shadow_q <= '0;
    end else begin
      prev_q   <= prev_d;
      live_q   <= live_d;
      shadow_q <= shadow_d;
    end
  end

  assign live_o   = live_q;
  assign shadow_o = shadow_q;

endmodule

// File: rtl/surf_l0_scaler_block.sv
// Per-channel scaler counters on the TURF scaler pulse bus, gated by an internal
// timer or the reference pulse, with a latched shadow bank and a registered read port.
module surf_l0_scaler_block
  import surf_scaler_pkg::*;
#(
  parameter int NCHAN         = NCHAN_DEF,
  parameter int COUNT_W       = COUNT_W_DEF,
  parameter int PERIOD_CYCLES = PERIOD_33MHZ_1S,
  parameter int REF_BIT       = REF_BIT_DEF
) (
  input  logic               mclk_i,
  input  logic               rst_n_i,
  input  logic [NCHAN-1:0]   scal_i,
  input  logic               gate_sel_i,
  input  logic               rd_en_i,
  input  logic [4:0]         rd_addr_i,
  output logic [COUNT_W-1:0] rd_data_o,
  output logic               rd_valid_o,
  output logic               new_data_o,
  input  logic               ack_i,
  output logic               overrun_o,
  output logic               period_tick_o
);

  localparam int TIMER_W = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(PERIOD_CYCLES - 1);

  gate_sel_e          gate_sel_q, gate_sel_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic               ref_prev_q, ref_prev_d;
  logic               new_data_q, new_data_d;
  logic               overrun_q, overrun_d;
  logic               rd_valid_q, rd_valid_d;
  logic [COUNT_W-1:0] rd_data_q, rd_data_d;
  logic [COUNT_W-1:0] rd_sel;
  logic               sel_change;
  logic               ref_edge;
  logic               boundary;

  // Live counts are only consumed inside each channel.
  logic [COUNT_W-1:0] live_unused [NCHAN];
  logic [COUNT_W-1:0] shadow      [NCHAN];

  for (genvar g = 0; g < NCHAN; g++) begin : g_chan
    surf_scaler_counter #(
      .COUNT_W (COUNT_W)
    ) u_cnt (
      .mclk_i     (mclk_i),
      .rst_n_i    (rst_n_i),
      .pulse_i    (scal_i[g]),
      .boundary_i (boundary),
      .live_o     (live_unused[g]),
      .shadow_o   (shadow[g])
    );
  end

  // Gate source selection and timer; a mode change restarts the timer without a boundary.
  always_comb begin
    gate_sel_d = gate_sel_e'(gate_sel_i);
    ref_prev_d = scal_i[REF_BIT];
    sel_change = (gate_sel_e'(gate_sel_i) != gate_sel_q);
    ref_edge   = scal_i[REF_BIT] & ~ref_prev_q;
    boundary   = 1'b0;
    timer_d    = timer_q + 1'b1;
    if (!sel_change) begin
      boundary = (gate_sel_q == GATE_REF) ? ref_edge : (timer_q == TIMER_LAST);
    end
    if (sel_change || (gate_sel_q == GATE_REF) || (timer_q == TIMER_LAST)) begin
      timer_d = '0;
    end
  end

  // New-data/overrun handshake; a boundary outranks a coincident ack.
  always_comb begin
    new_data_d = new_data_q;
    overrun_d  = overrun_q;
    if (boundary && new_data_q && !ack_i) begin
      overrun_d = 1'b1;
    end else if (ack_i && !new_data_q) begin
      overrun_d = 1'b0;
    end
    if (boundary) begin
      new_data_d = 1'b1;
    end else if (ack_i) begin
      new_data_d = 1'b0;
    end
  end

  // Read mux over the shadow bank; unmapped addresses read as zero, data holds when idle.
  always_comb begin
    rd_sel = '0;
    for (int i = 0; i < NCHAN; i++) begin
      if (int'(rd_addr_i) == i) rd_sel = shadow[i];
    end
    rd_valid_d = rd_en_i;
    rd_data_d  = rd_en_i ? rd_sel : rd_data_q;
  end

  // Control and read-port registers.
  always_ff @(posedge mclk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      gate_sel_q <= GATE_INTERNAL;
      timer_q    <= '0;
      ref_prev_q <= 1'b0;
      new_data_q <= 1'b0;
      overrun_q  <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      gate_sel_q <= gate_sel_d;
      timer_q    <= timer_d;
      ref_prev_q <= ref_prev_d;
      new_data_q <= new_data_d;
      overrun_q  <= overrun_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign rd_data_o     = rd_data_q;
  assign rd_valid_o    = rd_valid_q;
  assign new_data_o    = new_data_q;
  assign overrun_o     = overrun_q;
  assign period_tick_o = boundary;

endmodule

// File: tb/tb_surf_l0_scaler_block.sv
// Self-checking bench for surf_l0_scaler_block against a cycle-level behavioural model.
module tb_surf_l0_scaler_block;

  localparam int NCH  = 32;
  localparam int CW   = 8;
  localparam int P    = 100;
  localparam int RB   = 21;
  localparam int MAXC = 255;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [31:0]   scal;
  logic          gate_sel, rd_en, ack;
  logic [4:0]    rd_addr;
  logic [CW-1:0] rd_data;
  logic          rd_valid, new_data, overrun, period_tick;

  int checks = 0, errors = 0;
  int tick_dut = 0, tick_mod = 0;

  // Behavioural model state
  logic [31:0] m_prev;
  int          m_live [NCH];
  int          m_shadow [NCH];
  int          m_cnt;
  logic        m_sel, m_nd, m_ov, m_rv;
  int          m_rd;
  bit          last_bnd;

  surf_l0_scaler_block #(
    .NCHAN(NCH), .COUNT_W(CW), .PERIOD_CYCLES(P), .REF_BIT(RB)
  ) dut (
    .mclk_i(clk), .rst_n_i(rst_n), .scal_i(scal), .gate_sel_i(gate_sel),
    .rd_en_i(rd_en), .rd_addr_i(rd_addr), .rd_data_o(rd_data), .rd_valid_o(rd_valid),
    .new_data_o(new_data), .ack_i(ack), .overrun_o(overrun), .period_tick_o(period_tick)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_prev = '0;
    for (int i = 0; i < NCH; i++) begin m_live[i] = 0; m_shadow[i] = 0; end
    m_cnt = 0; m_sel = 1'b0; m_nd = 1'b0; m_ov = 1'b0; m_rv = 1'b0; m_rd = 0;
  endtask

  function automatic bit model_bnd();
    if (gate_sel != m_sel) return 1'b0;
    if (m_sel) return scal[RB] && !m_prev[RB];
    return m_cnt == P - 1;
  endfunction

  // One clock: inputs already applied at the negedge; returns at the next negedge.
  task automatic step();
    bit b, hit;
    #1;
    b = model_bnd();
    tick_dut += int'(period_tick);
    tick_mod += int'(b);
    @(posedge clk);
    if (rd_en) m_rd = (int'(rd_addr) < NCH) ? m_shadow[rd_addr] : 0;
    m_rv = rd_en;
    if (b && m_nd && !ack) m_ov = 1'b1;
    else if (ack && !m_nd) m_ov = 1'b0;
    m_nd = b ? 1'b1 : (ack ? 1'b0 : m_nd);
    for (int i = 0; i < NCH; i++) begin
      hit = scal[i] && !m_prev[i];
      if (b) begin
        m_shadow[i] = m_live[i];
        m_live[i]   = hit ? 1 : 0;
      end else if (hit && m_live[i] < MAXC) begin
        m_live[i]++;
      end
    end
    m_cnt  = ((gate_sel != m_sel) || m_sel || m_cnt == P - 1) ? 0 : m_cnt + 1;
    m_sel  = gate_sel;
    m_prev = scal;
    @(negedge clk);
    last_bnd = b;
  endtask

  task automatic idle();
    scal = '0; rd_en = 1'b0; ack = 1'b0;
  endtask

  task automatic pulse_ch(input int ch, input int n);
    for (int k = 0; k < n; k++) begin
      scal = '0; scal[ch] = 1'b1; step();
      scal = '0; step();
    end
  endtask

  task automatic wait_tick();
    int n = 0;
    idle();
    last_bnd = 1'b0;
    while (!last_bnd && n < 3 * P) begin step(); n++; end
    checks++;
    if (!last_bnd) begin errors++; $display("FAIL wait_tick: no boundary within %0d cycles", n); end
  endtask

  task automatic wait_last();
    int n = 0;
    idle();
    while (m_cnt != P - 1 && n < 3 * P) begin step(); n++; end
    checks++;
    if (m_cnt != P - 1) begin errors++; $display("FAIL wait_last: timer never reached %0d", P - 1); end
  endtask

  task automatic do_ack();
    idle(); ack = 1'b1; step(); ack = 1'b0;
  endtask

  task automatic read_ch(input int a, output logic [CW-1:0] v, output logic vld);
    idle(); rd_en = 1'b1; rd_addr = a[4:0]; step();
    rd_en = 1'b0; v = rd_data; vld = rd_valid;
  endtask

  task automatic test_reset();
    idle(); gate_sel = 1'b0; rd_addr = '0;
    rst_n = 1'b1; #1 rst_n = 1'b0; #1;
    checks++;
    if (rd_data !== '0 || rd_valid !== 1'b0 || new_data !== 1'b0 || overrun !== 1'b0 || period_tick !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got rd_data=%0d rd_valid=%b new_data=%b overrun=%b tick=%b, want all 0",
               rd_data, rd_valid, new_data, overrun, period_tick);
    end
    model_reset();
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic_count();
    logic [CW-1:0] v; logic vld;
    wait_tick(); do_ack();
    pulse_ch(3, 10);
    wait_tick();
    checks++;
    if (new_data !== 1'b1) begin errors++; $display("FAIL basic_new_data: got %b want 1", new_data); end
    read_ch(3, v, vld);
    checks++;
    if (v !== 8'd10 || v !== m_rd[CW-1:0] || vld !== 1'b1) begin
      errors++; $display("FAIL basic_ch3: got %0d vld=%b want 10 vld=1", v, vld);
    end
    idle(); step();
    checks++;
    if (rd_valid !== 1'b0 || rd_data !== 8'd10) begin
      errors++; $display("FAIL basic_hold: got rd_valid=%b rd_data=%0d want 0 and 10", rd_valid, rd_data);
    end
    for (int c = 0; c < NCH; c++) begin
      if (c == 3) continue;
      read_ch(c, v, vld);
      checks++;
      if (v !== 8'd0 || v !== m_rd[CW-1:0]) begin
        errors++; $display("FAIL basic_other ch%0d: got %0d want 0", c, v);
      end
    end
  endtask

  task automatic test_held_level();
    logic [CW-1:0] v; logic vld;
    wait_tick(); do_ack();
    scal = '0; scal[7] = 1'b1;
    for (int k = 0; k < 40; k++) step();
    scal = '0; step();
    pulse_ch(9, 5);
    wait_tick();
    read_ch(7, v, vld);
    checks++;
    if (v !== 8'd1 || v !== m_rd[CW-1:0]) begin errors++; $display("FAIL held_ch7: got %0d want 1", v); end
    read_ch(9, v, vld);
    checks++;
    if (v !== 8'd5 || v !== m_rd[CW-1:0]) begin errors++; $display("FAIL toggle_ch9: got %0d want 5", v); end
  endtask

  task automatic test_boundary_coincide();
    logic [CW-1:0] v, old_v; logic vld;
    wait_tick(); do_ack();
    read_ch(5, old_v, vld);
    pulse_ch(5, 4);
    wait_last();
    scal = '0; scal[5] = 1'b1; rd_en = 1'b1; rd_addr = 5'd5;
    step();
    idle();
    checks++;
    if (last_bnd !== 1'b1 || rd_data !== old_v) begin
      errors++; $display("FAIL bnd_read_old: got rd_data=%0d want old %0d", rd_data, old_v);
    end
    read_ch(5, v, vld);
    checks++;
    if (v !== 8'd4 || v !== m_rd[CW-1:0]) begin errors++; $display("FAIL bnd_shadow: got %0d want 4", v); end
    pulse_ch(5, 2);
    wait_tick();
    read_ch(5, v, vld);
    checks++;
    if (v !== 8'd3 || v !== m_rd[CW-1:0]) begin errors++; $display("FAIL bnd_next: got %0d want 3", v); end
  endtask

  task automatic test_handshake();
    wait_tick(); do_ack();
    wait_tick();
    wait_tick();
    checks++;
    if (overrun !== 1'b1 || new_data !== 1'b1 || overrun !== m_ov) begin
      errors++; $display("FAIL overrun_set: got overrun=%b new_data=%b want 1 1", overrun, new_data);
    end
    do_ack();
    checks++;
    if (new_data !== 1'b0 || overrun !== 1'b1) begin
      errors++; $display("FAIL ack_first: got new_data=%b overrun=%b want 0 1", new_data, overrun);
    end
    do_ack();
    checks++;
    if (overrun !== 1'b0 || new_data !== 1'b0) begin
      errors++; $display("FAIL ack_clear_ovr: got overrun=%b new_data=%b want 0 0", overrun, new_data);
    end
    wait_tick();
    wait_last();
    ack = 1'b1; step(); ack = 1'b0;
    checks++;
    if (last_bnd !== 1'b1 || new_data !== 1'b1 || overrun !== 1'b0 || new_data !== m_nd) begin
      errors++; $display("FAIL ack_at_tick: got new_data=%b overrun=%b want 1 0", new_data, overrun);
    end
  endtask

  task automatic test_saturation();
    logic [CW-1:0] v; logic vld;
    idle(); gate_sel = 1'b1; step();
    scal[RB] = 1'b1; step(); scal = '0;
    checks++;
    if (last_bnd !== 1'b1) begin errors++; $display("FAIL ref_first_edge: got %b want 1", last_bnd); end
    do_ack();
    pulse_ch(0, 300);
    scal = '0; scal[RB] = 1'b1; step(); scal = '0;
    read_ch(0, v, vld);
    checks++;
    if (v !== 8'd255 || v !== m_rd[CW-1:0]) begin errors++; $display("FAIL sat_ch0: got %0d want 255", v); end
    read_ch(RB, v, vld);
    checks++;
    if (v !== 8'd1 || v !== m_rd[CW-1:0]) begin errors++; $display("FAIL ref_bit_count: got %0d want 1", v); end
    do_ack();
    pulse_ch(0, 2);
    scal = '0; scal[RB] = 1'b1; step(); scal = '0;
    read_ch(0, v, vld);
    checks++;
    if (v !== 8'd2 || v !== m_rd[CW-1:0]) begin errors++; $display("FAIL sat_recover: got %0d want 2", v); end
  endtask

  task automatic test_ref_mode();
    logic [CW-1:0] v; logic vld;
    int ph, expc;
    for (int r = 0; r < 2; r++) begin
      ph = $urandom_range(0, 2);
      expc = 0;
      for (int c = 0; c < 112; c++) begin
        idle();
        scal[RB] = (c % 37 == 0);
        scal[2]  = ((c + ph) % 3 == 0);
        if (c >= 74 && c <= 110 && scal[2]) expc++;
        step();
      end
      read_ch(2, v, vld);
      checks++;
      if (int'(v) != expc || v !== m_rd[CW-1:0] || v < 8'd12 || v > 8'd13) begin
        errors++; $display("FAIL ref_gate_ch2 phase%0d: got %0d want %0d", ph, v, expc);
      end
    end
  endtask

  task automatic test_random();
    idle(); gate_sel = 1'b0; step();
    for (int c = 0; c < 250; c++) begin
      scal    = $urandom & $urandom & $urandom;
      ack     = ($urandom_range(0, 15) == 0);
      rd_en   = $urandom_range(0, 1);
      rd_addr = 5'($urandom_range(0, 31));
      step();
      checks++;
      if (rd_data !== m_rd[CW-1:0] || rd_valid !== m_rv || new_data !== m_nd || overrun !== m_ov) begin
        errors++;
        $display("FAIL random cyc%0d: got data=%0d vld=%b nd=%b ov=%b want data=%0d vld=%b nd=%b ov=%b",
                 c, rd_data, rd_valid, new_data, overrun, m_rd, m_rv, m_nd, m_ov);
      end
    end
    idle();
  endtask

  task automatic test_reset_mid();
    logic [CW-1:0] v; logic vld;
    wait_tick();
    pulse_ch(4, 5);
    scal = '0; scal[6] = 1'b1;
    #2 rst_n = 1'b0; #1;
    checks++;
    if (rd_data !== '0 || rd_valid !== 1'b0 || new_data !== 1'b0 || overrun !== 1'b0 || period_tick !== 1'b0) begin
      errors++;
      $display("FAIL midreset_outputs: got rd_data=%0d rd_valid=%b new_data=%b overrun=%b tick=%b, want all 0",
               rd_data, rd_valid, new_data, overrun, period_tick);
    end
    model_reset();
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) step();
    scal = '0; step();
    pulse_ch(4, 3);
    wait_tick();
    read_ch(4, v, vld);
    checks++;
    if (v !== 8'd3 || v !== m_rd[CW-1:0]) begin errors++; $display("FAIL postreset_ch4: got %0d want 3", v); end
    read_ch(6, v, vld);
    checks++;
    if (v !== 8'd1 || v !== m_rd[CW-1:0]) begin errors++; $display("FAIL postreset_ch6: got %0d want 1", v); end
  endtask

  initial begin
    test_reset();
    test_basic_count();
    test_held_level();
    test_boundary_coincide();
    test_handshake();
    test_saturation();
    test_ref_mode();
    test_random();
    test_reset_mid();
    checks++;
    if (tick_dut != tick_mod) begin
      errors++; $display("FAIL tick_count: got %0d want %0d", tick_dut, tick_mod);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
